bitmap_read_arbiter: RTL

//   Shares the single game-bitmap row read port between two requesters:

---
 rtl/bitmap_read_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bitmap_read_arbiter.sv
// Bitmap row read arbiter: shares one fixed-latency bitmap-store read port
// between the real-time HDMI renderer (port 0) and the best-effort UART dump
// (port 1). Port 0 has priority; a starvation counter forces a port 1 grant
// after STARVE_LIMIT consecutive port 0 grants taken while port 1 waited.
// Only one read is ever in flight.
module bitmap_read_arbiter #(
  parameter int ROW_ADDR_W   = 5,
  parameter int DATA_W       = 32,
  parameter int READ_LAT     = 1,   // 1..7
  parameter int STARVE_LIMIT = 4    // 1..15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_req,
  input  logic [ROW_ADDR_W-1:0] r0_row,
  output logic                  r0_valid,
  output logic [DATA_W-1:0]     r0_data,
  input  logic                  r1_req,
  input  logic [ROW_ADDR_W-1:0] r1_row,
  output logic                  r1_valid,
  output logic [DATA_W-1:0]     r1_data,
  output logic                  mem_rd_en,
  output logic [ROW_ADDR_W-1:0] mem_row,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  busy
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [2:0] LAT_LOAD   = 3'(READ_LAT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [3:0] STARVE_SAT = 4'd15;

  state_t          state_q, state_d;
  logic            issue;       // start a read this edge
  logic            grant;       // winner of the arbitration: 0 or 1
  logic            capture;     // read data is valid at this edge
  logic            owner;       // port that owns the in-flight read
  logic [2:0]      lat_cnt;     // edges left until mem_data is valid
  logic [3:0]      starve_cnt;  // port 0 grants taken while port 1 waited

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update together from the values seen before the edge.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, arbitration and issue/capture decisions.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d = state_q;
    issue   = 1'b0;
    grant   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (r0_req || r1_req) begin
          issue   = 1'b1;
          grant   = r1_req && (!r0_req || (starve_cnt >= STARVE_MAX));
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt == 3'd0) begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read issue, latency countdown and per-port response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data registers are reset too, so every output reads 0 after
      // reset and an abandoned read leaves nothing behind.
      mem_rd_en <= 1'b0;
      mem_row   <= '0;
      owner     <= 1'b0;
      lat_cnt   <= 3'd0;
      r0_valid  <= 1'b0;
      r1_valid  <= 1'b0;
      r0_data   <= '0;
      r1_data   <= '0;
    end else begin
      mem_rd_en <= issue;
      r0_valid  <= capture && !owner;
      r1_valid  <= capture &&  owner;
      if (issue) begin
        owner   <= grant;
        mem_row <= grant ? r1_row : r0_row;
        lat_cnt <= LAT_LOAD;
      end else if (state_q == WAIT && lat_cnt != 3'd0) begin
        lat_cnt <= lat_cnt - 3'd1;
      end
      if (capture && !owner) r0_data <= mem_data;
      if (capture &&  owner) r1_data <= mem_data;
    end
  end

  // Starvation guard: counts port 0 wins over a waiting port 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (state_q == IDLE) begin
      if (issue && grant)
        starve_cnt <= 4'd0;
      else if (issue && r1_req)
        starve_cnt <= (starve_cnt == STARVE_SAT) ? STARVE_SAT : starve_cnt + 4'd1;
      else if (!r1_req)
        starve_cnt <= 4'd0;
    end
  end

  assign busy = (state_q == WAIT);

endmodule
